// File: rtl/mul_pkg.sv
// Shared definitions for the M-extension multiplier: op codes, FSM
// encodings and the conditional two's-complement negate.
package mul_pkg;

  localparam int XLEN_MAX = 32;
  localparam int WIDE     = 2 * XLEN_MAX;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    CORRECT  = 2'd2
  } state_e;

  // Negate over the full double width when neg is set. Callers zero-extend
  // narrower values in and truncate the result, so one helper covers both
  // the operand magnitudes and the final sign correction.
  function automatic logic [WIDE-1:0] cond_neg(input logic [WIDE-1:0] v,
                                               input logic            neg);
    return neg ? (~v + WIDE'(1)) : v;
  endfunction

endpackage

// File: rtl/multiply_unit_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface multiply_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic [1:0]      mul_op;
  logic            data_valid;
  logic [XLEN-1:0] product;
  logic            data_ready;
  logic            busy;

  modport master (
    output multiplicand, multiplier, mul_op, data_valid,
    input  product, data_ready, busy
  );

  modport slave (
    input  multiplicand, multiplier, mul_op, data_valid,
    output product, data_ready, busy
  );
endinterface

// File: rtl/multiply_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied unsigned over XLEN cycles,
// then sign-corrected and half-selected in one final cycle.
//
// state    | meaning
// IDLE     | waiting for data_valid; data_ready pulses here after a result
// MULTIPLY | one shift-add iteration per cycle, XLEN cycles
// CORRECT  | negate the double-width result if needed, pick the half
module multiply_unit
  import mul_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = $clog2(XLEN)
) (
  input  logic             CLK,
  input  logic             rst,
  multiply_unit_if.slave   bus
);

  localparam int DW = 2 * XLEN;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic                   neg_q, neg_d;
  logic [XLEN-1:0]        mcand_q, mcand_d;
  logic [XLEN-1:0]        mplier_q, mplier_d;
  logic [XLEN:0]          acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]        product_q, product_d;
  logic                   ready_q, ready_d;

  logic                   a_signed, b_signed, a_neg, b_neg;
  logic [XLEN:0]          sum;
  logic [DW-1:0]          raw, res;

  // State register
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; all cleared so nothing starts as X
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      op_q      <= op_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready_d   = 1'b0;

    a_signed  = (bus.mul_op != OP_MULHU);
    b_signed  = (bus.mul_op == OP_MUL) || (bus.mul_op == OP_MULH);
    a_neg     = a_signed & bus.multiplicand[XLEN-1];
    b_neg     = b_signed & bus.multiplier[XLEN-1];

    // acc stays below 2^XLEN after each shift, so the carry bit is only
    // ever set transiently by this add and is shifted back in below.
    sum       = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    raw       = {acc_q[XLEN-1:0], mplier_q};
    res       = DW'(cond_neg(WIDE'(raw), neg_q));

    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          op_d     = bus.mul_op;
          neg_d    = a_neg ^ b_neg;
          // Magnitude of the most negative value comes out as 2^(XLEN-1),
          // which fits because the latched operands are unsigned.
          mcand_d  = XLEN'(cond_neg(WIDE'(bus.multiplicand), a_neg));
          mplier_d = XLEN'(cond_neg(WIDE'(bus.multiplier), b_neg));
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULTIPLY;
        end
      end
      MULTIPLY: begin
        acc_d    = {1'b0, sum[XLEN:1]};
        mplier_d = {sum[0], mplier_q[XLEN-1:1]};
        cnt_d    = cnt_q + COUNT_WIDTH'(1);
        if (&cnt_q) state_d = CORRECT;
      end
      CORRECT: begin
        product_d = (op_q == OP_MUL) ? res[XLEN-1:0] : res[DW-1:XLEN];
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.product    = product_q;
  assign bus.data_ready = ready_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_multiply_unit.sv
// Directed bench for multiply_unit with a cycle-level reference model.
module tb_multiply_unit;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;
  localparam int LAT = 33;   // accept edge k -> data_ready visible after edge k+33

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  multiply_unit_if #(.XLEN(32)) bus();

  multiply_unit #(.XLEN(32)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    int          k;
  } exp_t;

  exp_t q[$];
  int   next_free = 0;
  int   last_k    = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  // Full-precision product of the operands as RV32M interprets them.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op != MULHU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-by-cycle compare of busy/data_ready/product against the model.
  always @(negedge CLK) begin
    if (!rst) begin
      logic exp_busy;
      logic exp_ready;
      exp_busy = 1'b0;
      foreach (q[i]) if (cyc >= q[i].k && cyc <= q[i].k + LAT - 1) exp_busy = 1'b1;
      exp_ready = (q.size() > 0) && (cyc == q[0].k + LAT);
      chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      chk("data_ready", {31'd0, bus.data_ready}, {31'd0, exp_ready});
      if (exp_ready) begin
        chk("product_vs_model", bus.product, q[0].exp);
        void'(q.pop_front());
      end
    end
  end

  // Called just after a negedge: present a request for one clock.
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int e;
    bus.mul_op       = op;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.data_valid   = 1'b1;
    e = cyc + 1;
    if (e >= next_free) begin
      q.push_back('{exp: model(op, a, b), k: e});
      next_free = e + LAT + 1;
      last_k    = e;
    end
    @(posedge CLK);
    #1 bus.data_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name, input logic [31:0] lit);
    for (int i = 0; i < 45; i++) begin
      @(negedge CLK);
      if (bus.data_ready) break;
    end
    chk({name, "_latency"}, cyc, last_k + LAT);
    chk(name, bus.product, lit);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit);
    chk({name, "_model_pin"}, model(op, a, b), lit);
    @(negedge CLK);
    drive(op, a, b);
    wait_ready(name, lit);
  endtask

  initial begin
    bus.mul_op       = MUL;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.data_valid   = 1'b0;

    #1;
    chk("reset_product", bus.product, 32'h0);
    chk("reset_ready", {31'd0, bus.data_ready}, 32'h0);
    chk("reset_busy", {31'd0, bus.busy}, 32'h0);
    repeat (2) @(negedge CLK);
    rst = 1'b0;

    run("mul_7_m3",        MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run("mulh_min_min",    MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    run("mulhu_min_min",   MULHU,  32'h80000000, 32'h80000000, 32'h40000000);
    run("mul_min_min",     MUL,    32'h80000000, 32'h80000000, 32'h00000000);
    run("mulhsu_m1_max",   MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("mulhu_max_max",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("mulh_m1_m1",      MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run("mulhsu_min_2p31", MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000);

    // Back-to-back: second request in the data_ready cycle, then ignored
    // requests while busy.
    chk("b2b_model_pin", model(MULHU, 32'h00010000, 32'h00010000), 32'h00000001);
    @(negedge CLK);
    drive(MUL, 32'h12345678, 32'h00000010);
    wait_ready("b2b_first", 32'h23456780);
    drive(MULHU, 32'h00010000, 32'h00010000);
    repeat (5) @(negedge CLK);
    drive(MUL, 32'h00000005, 32'h00000005);
    repeat (3) @(negedge CLK);
    drive(MULH, 32'hFFFFFFFF, 32'h00000001);
    wait_ready("b2b_second", 32'h00000001);

    // Abort mid-MULTIPLY with an asynchronous reset.
    @(negedge CLK);
    drive(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    while (cyc < last_k + 10) @(negedge CLK);
    rst = 1'b1;
    #1;
    q.delete();
    next_free = 0;
    chk("abort_product", bus.product, 32'h0);
    chk("abort_ready", {31'd0, bus.data_ready}, 32'h0);
    chk("abort_busy", {31'd0, bus.busy}, 32'h0);
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    repeat (40) @(negedge CLK);

    run("mulh_m2_3",   MULH,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    run("mul_m2_3",    MUL,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA);
    run("mulhu_zero",  MULHU, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);

    repeat (3) @(negedge CLK);
    chk("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
